// File: rtl/mac_table_arbiter.sv
// Sequences the single-port MAC table between pPORTS lookup/learn requesters and an aging scanner.
// The aging scanner exists only when MAC_TABLE_AGING_EN is defined; otherwise requesters own every slot.
module mac_table_arbiter #(
    parameter int pPORTS      = 4,
    parameter int pADRESS     = 2,
    parameter int pSLOTS      = 16384,
    parameter int pTIME       = 9,
    parameter int pAGE_INIT   = 300,
    parameter int pAGE_PERIOD = 131072
) (
    input  logic                             iclk,
    input  logic                             i_rst_n,
    input  logic [pPORTS-1:0]                i_req,
    input  logic [pPORTS-1:0]                i_learn,
    input  logic [pPORTS*$clog2(pSLOTS)-1:0] i_key,
    input  logic [pPORTS*pADRESS-1:0]        i_src_port,
    output logic [pPORTS-1:0]                o_grant,
    output logic                             o_resp_valid,
    output logic [pPORTS-1:0]                o_resp_req,
    output logic                             o_resp_hit,
    output logic [pADRESS-1:0]               o_resp_port,
    output logic                             o_mem_en,
    output logic                             o_mem_we,
    output logic [$clog2(pSLOTS)-1:0]        o_mem_addr,
    output logic [pADRESS-1:0]               o_mem_wport,
    output logic [pTIME-1:0]                 o_mem_wtime,
    input  logic [pADRESS-1:0]               i_mem_rport,
    input  logic [pTIME-1:0]                 i_mem_rtime,
    output logic                             o_age_busy,
    output logic                             o_age_overrun
);
    localparam int KW = $clog2(pSLOTS);
    localparam int PW = (pPORTS > 1) ? $clog2(pPORTS) : 1;

    typedef enum logic [2:0] {IDLE, LK_RD, LK_RSP, LRN_WR, AGE_RD, AGE_WR} state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      rr_q, rr_d;
    logic [pPORTS-1:0]  owner_q, owner_d;
    logic [pPORTS-1:0]  grant_q, grant_d;
    logic               resp_valid_q, resp_valid_d;
    logic [pPORTS-1:0]  resp_req_q, resp_req_d;
    logic               resp_hit_q, resp_hit_d;
    logic [pADRESS-1:0] resp_port_q, resp_port_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [KW-1:0]      mem_addr_q, mem_addr_d;
    logic [pADRESS-1:0] mem_wport_q, mem_wport_d;
    logic [pTIME-1:0]   mem_wtime_q, mem_wtime_d;

    logic               found;
    logic [PW-1:0]      sel, idx;
    logic [KW-1:0]      key_sel;
    logic [pADRESS-1:0] src_sel;
    logic               learn_sel;

    // Round-robin search starting at the pointer, then mux out the winner's request fields.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 0; i < pPORTS; i++) begin
            idx = PW'((int'(rr_q) + i) % pPORTS);
            if (!found && i_req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        key_sel   = '0;
        src_sel   = '0;
        learn_sel = 1'b0;
        for (int p = 0; p < pPORTS; p++) begin
            if (sel == PW'(p)) begin
                key_sel   = i_key[p*KW +: KW];
                src_sel   = i_src_port[p*pADRESS +: pADRESS];
                learn_sel = i_learn[p];
            end
        end
    end

`ifdef MAC_TABLE_AGING_EN
    localparam int TW = $clog2(pAGE_PERIOD);

    logic [TW-1:0] tick_q;
    logic          tick_wrap;
    logic [KW-1:0] index_q, index_d;
    logic          age_busy_q, age_busy_d;
    logic          overrun_q, overrun_d;
    logic          last_req_q, last_req_d;
    logic          scan_go;

    assign tick_wrap = (tick_q == TW'(pAGE_PERIOD - 1));
    // Requesters and the scanner alternate when both are pending.
    assign scan_go   = age_busy_q && ((i_req == '0) || last_req_q);

    always_ff @(posedge iclk) begin
        if (!i_rst_n) begin
            tick_q     <= '0;
            index_q    <= '0;
            age_busy_q <= 1'b0;
            overrun_q  <= 1'b0;
            last_req_q <= 1'b0;
        end else begin
            tick_q     <= tick_wrap ? '0 : tick_q + TW'(1);
            index_q    <= index_d;
            age_busy_q <= age_busy_d;
            overrun_q  <= overrun_d;
            last_req_q <= last_req_d;
        end
    end

    assign o_age_busy    = age_busy_q;
    assign o_age_overrun = overrun_q;
`else
    assign o_age_busy    = 1'b0;
    assign o_age_overrun = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        owner_d      = owner_q;
        grant_d      = '0;
        resp_valid_d = 1'b0;
        resp_req_d   = '0;
        resp_hit_d   = 1'b0;
        resp_port_d  = '0;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = '0;
        mem_wport_d  = '0;
        mem_wtime_d  = '0;
`ifdef MAC_TABLE_AGING_EN
        index_d      = index_q;
        last_req_d   = last_req_q;
        age_busy_d   = age_busy_q;
        overrun_d    = overrun_q | (tick_wrap & age_busy_q);
        if (tick_wrap && !age_busy_q) begin
            age_busy_d = 1'b1;
            index_d    = '0;
        end
`endif
        case (state_q)
            IDLE: begin
`ifdef MAC_TABLE_AGING_EN
                if (scan_go) begin
                    state_d    = AGE_RD;
                    mem_en_d   = 1'b1;
                    mem_addr_d = index_q;
                    last_req_d = 1'b0;
                end else if (found) begin
                    last_req_d = 1'b1;
`else
                if (found) begin
`endif
                    grant_d[sel] = 1'b1;
                    rr_d         = PW'((int'(sel) + 1) % pPORTS);
                    mem_en_d     = 1'b1;
                    mem_addr_d   = key_sel;
                    if (learn_sel) begin
                        state_d     = LRN_WR;
                        mem_we_d    = 1'b1;
                        mem_wport_d = src_sel;
                        mem_wtime_d = pTIME'(pAGE_INIT);
                    end else begin
                        state_d      = LK_RD;
                        owner_d      = '0;
                        owner_d[sel] = 1'b1;
                    end
                end
            end
            LK_RD:  state_d = LK_RSP;
            LK_RSP: begin
                state_d      = IDLE;
                resp_valid_d = 1'b1;
                resp_req_d   = owner_q;
                resp_hit_d   = (i_mem_rtime != '0);
                resp_port_d  = (i_mem_rtime != '0) ? i_mem_rport : '0;
            end
            LRN_WR: state_d = IDLE;
`ifdef MAC_TABLE_AGING_EN
            AGE_RD: state_d = AGE_WR;
            AGE_WR: begin
                // Read data for slot[index] is on the bus now; empty slots are left untouched.
                state_d = IDLE;
                if (i_mem_rtime != '0) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = index_q;
                    mem_wport_d = i_mem_rport;
                    mem_wtime_d = i_mem_rtime - pTIME'(1);
                end
                if (index_q == KW'(pSLOTS - 1)) begin
                    index_d    = '0;
                    age_busy_d = 1'b0;
                end else begin
                    index_d    = index_q + KW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            rr_q         <= '0;
            owner_q      <= '0;
            grant_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_req_q   <= '0;
            resp_hit_q   <= 1'b0;
            resp_port_q  <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wport_q  <= '0;
            mem_wtime_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            owner_q      <= owner_d;
            grant_q      <= grant_d;
            resp_valid_q <= resp_valid_d;
            resp_req_q   <= resp_req_d;
            resp_hit_q   <= resp_hit_d;
            resp_port_q  <= resp_port_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wport_q  <= mem_wport_d;
            mem_wtime_q  <= mem_wtime_d;
        end
    end

    assign o_grant      = grant_q;
    assign o_resp_valid = resp_valid_q;
    assign o_resp_req   = resp_req_q;
    assign o_resp_hit   = resp_hit_q;
    assign o_resp_port  = resp_port_q;
    assign o_mem_en     = mem_en_q;
    assign o_mem_we     = mem_we_q;
    assign o_mem_addr   = mem_addr_q;
    assign o_mem_wport  = mem_wport_q;
    assign o_mem_wtime  = mem_wtime_q;

endmodule
